// File: rtl/cv32e40n_xbar_pkg.sv
// Shared types and constants for the cv32e40n data-side crossbar blocks.
// Holds the target encoding, the internal responder read value and the
// address decode helper used by the demultiplexer.
package cv32e40n_xbar_pkg;

    typedef enum logic [1:0] {
        TGT_S1  = 2'd0,
        TGT_S2  = 2'd1,
        TGT_DEF = 2'd2
    } tgt_e;

    localparam logic [31:0] DEFAULT_RDATA = 32'hBADA_DD12;

    // s2 wins over s1; addresses outside both regions go to the internal
    // responder when it exists, otherwise they fall back onto s1.
    function automatic tgt_e decode_target(
        input logic [31:0] addr,
        input logic [31:0] s1_base,
        input logic [31:0] s1_mask,
        input logic [31:0] s2_base,
        input logic [31:0] s2_mask,
        input logic        def_en
    );
        if ((addr & s2_mask) == s2_base) begin
            return TGT_S2;
        end else if ((addr & s1_mask) == s1_base) begin
            return TGT_S1;
        end else if (def_en) begin
            return TGT_DEF;
        end else begin
            return TGT_S1;
        end
    endfunction

endpackage

// File: rtl/cv32e40n_demux_default_slave.sv
// Internal responder for unmapped data accesses.
// Only used when CV32E40N_DEMUX_DEFAULT_RESP_EN is defined. Always ready to
// accept, answers every accepted access one cycle later with DEFAULT_RDATA
// and silently drops write data.
module cv32e40n_demux_default_slave
    import cv32e40n_xbar_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        accept_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    logic rvalid_reg;

    assign gnt_o    = 1'b1;
    assign rvalid_o = rvalid_reg;
    assign rdata_o  = DEFAULT_RDATA;

    // Response follows each accepted access by exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= accept_i;
        end
    end

endmodule

// File: rtl/cv32e40n_data_demux.sv
// Data-side demultiplexer: one OBI-style master to a RAM slave (s1) and a
// peripheral slave (s2). Tracks granted-but-unanswered transactions and only
// lets new ones through to the slave that currently owns them, so responses
// always come back in order.
// Optional feature: CV32E40N_DEMUX_DEFAULT_RESP_EN adds an internal responder
// for unmapped addresses; without it unmapped accesses go to s1.
module cv32e40n_data_demux
    import cv32e40n_xbar_pkg::*;
#(
    parameter logic [31:0] S1_ADDR_BASE    = 32'h0000_0000,
    parameter logic [31:0] S1_ADDR_MASK    = 32'hFFF0_0000,
    parameter logic [31:0] S2_ADDR_BASE    = 32'h1500_0000,
    parameter logic [31:0] S2_ADDR_MASK    = 32'hFF00_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_be_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        data_req_s1_o,
    output logic        data_we_s1_o,
    output logic [31:0] data_addr_s1_o,
    output logic [31:0] data_wdata_s1_o,
    output logic [3:0]  data_be_s1_o,
    input  logic        data_gnt_s1_i,
    input  logic        data_rvalid_s1_i,
    input  logic [31:0] data_rdata_s1_i,

    output logic        data_req_s2_o,
    output logic        data_we_s2_o,
    output logic [31:0] data_addr_s2_o,
    output logic [31:0] data_wdata_s2_o,
    output logic [3:0]  data_be_s2_o,
    input  logic        data_gnt_s2_i,
    input  logic        data_rvalid_s2_i,
    input  logic [31:0] data_rdata_s2_i
);

    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);
`ifdef CV32E40N_DEMUX_DEFAULT_RESP_EN
    localparam logic           DEF_EN  = 1'b1;
`else
    localparam logic           DEF_EN  = 1'b0;
`endif

    logic [CW-1:0] cnt_reg, cnt_next;
    tgt_e          cur_tgt_reg, cur_tgt_next;

    tgt_e          tgt;
    logic          issue_ok;
    logic          sel_gnt;
    logic          accept;
    logic          resp_valid;
    logic [31:0]   resp_rdata;

    logic          def_gnt;
    logic          def_rvalid;
    logic [31:0]   def_rdata;

    assign tgt = decode_target(data_addr_i, S1_ADDR_BASE, S1_ADDR_MASK,
                               S2_ADDR_BASE, S2_ADDR_MASK, DEF_EN);

    // A new access may only join the outstanding ones if it goes to the same
    // target; a switch waits until the old target has fully drained.
    assign issue_ok = (cnt_reg < MAX_CNT) && ((cnt_reg == '0) || (tgt == cur_tgt_reg));

    // Pick the grant of the decoded target.
    always_comb begin
        sel_gnt = 1'b0;
        case (tgt)
            TGT_S1:  sel_gnt = data_gnt_s1_i;
            TGT_S2:  sel_gnt = data_gnt_s2_i;
            TGT_DEF: sel_gnt = def_gnt;
            default: sel_gnt = 1'b0;
        endcase
    end

    assign data_gnt_o    = issue_ok & sel_gnt;
    assign accept        = data_req_i & data_gnt_o;

    assign data_req_s1_o = issue_ok & data_req_i & (tgt == TGT_S1);
    assign data_req_s2_o = issue_ok & data_req_i & (tgt == TGT_S2);

    assign data_we_s1_o    = data_we_i;
    assign data_addr_s1_o  = data_addr_i;
    assign data_wdata_s1_o = data_wdata_i;
    assign data_be_s1_o    = data_be_i;
    assign data_we_s2_o    = data_we_i;
    assign data_addr_s2_o  = data_addr_i;
    assign data_wdata_s2_o = data_wdata_i;
    assign data_be_s2_o    = data_be_i;

    // Responses are taken only from the target that owns the outstanding accesses.
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = data_rdata_s1_i;
        case (cur_tgt_reg)
            TGT_S1: begin
                resp_valid = data_rvalid_s1_i;
                resp_rdata = data_rdata_s1_i;
            end
            TGT_S2: begin
                resp_valid = data_rvalid_s2_i;
                resp_rdata = data_rdata_s2_i;
            end
            TGT_DEF: begin
                resp_valid = def_rvalid;
                resp_rdata = def_rdata;
            end
            default: begin
                resp_valid = 1'b0;
                resp_rdata = data_rdata_s1_i;
            end
        endcase
    end

    assign data_rvalid_o = (cnt_reg != '0) & resp_valid;
    assign data_rdata_o  = resp_rdata;

`ifdef CV32E40N_DEMUX_DEFAULT_RESP_EN
    cv32e40n_demux_default_slave u_default_slave (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .accept_i (accept & (tgt == TGT_DEF)),
        .gnt_o    (def_gnt),
        .rvalid_o (def_rvalid),
        .rdata_o  (def_rdata)
    );
`else
    assign def_gnt    = 1'b0;
    assign def_rvalid = 1'b0;
    assign def_rdata  = 32'h0000_0000;
`endif

    // Next outstanding count and owning target.
    always_comb begin
        cnt_next     = cnt_reg;
        cur_tgt_next = cur_tgt_reg;
        case ({accept, data_rvalid_o})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
        endcase
        if (accept) begin
            cur_tgt_next = tgt;
        end
    end

    // Outstanding-transaction state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg     <= '0;
            cur_tgt_reg <= TGT_S1;
        end else begin
            cnt_reg     <= cnt_next;
            cur_tgt_reg <= cur_tgt_next;
        end
    end

endmodule

// File: tb/tb_cv32e40n_data_demux.sv
// Testbench for cv32e40n_data_demux: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model of the
// master-visible behaviour and of two slaves with random latency.
module tb_cv32e40n_data_demux;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_req_s1_o, data_we_s1_o, data_req_s2_o, data_we_s2_o;
    logic [31:0] data_addr_s1_o, data_wdata_s1_o, data_addr_s2_o, data_wdata_s2_o;
    logic [3:0]  data_be_s1_o, data_be_s2_o;
    logic        data_gnt_s1_i, data_rvalid_s1_i, data_gnt_s2_i, data_rvalid_s2_i;
    logic [31:0] data_rdata_s1_i, data_rdata_s2_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cv32e40n_data_demux dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_req_s1_o(data_req_s1_o), .data_we_s1_o(data_we_s1_o), .data_addr_s1_o(data_addr_s1_o),
        .data_wdata_s1_o(data_wdata_s1_o), .data_be_s1_o(data_be_s1_o),
        .data_gnt_s1_i(data_gnt_s1_i), .data_rvalid_s1_i(data_rvalid_s1_i), .data_rdata_s1_i(data_rdata_s1_i),
        .data_req_s2_o(data_req_s2_o), .data_we_s2_o(data_we_s2_o), .data_addr_s2_o(data_addr_s2_o),
        .data_wdata_s2_o(data_wdata_s2_o), .data_be_s2_o(data_be_s2_o),
        .data_gnt_s2_i(data_gnt_s2_i), .data_rvalid_s2_i(data_rvalid_s2_i), .data_rdata_s2_i(data_rdata_s2_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_wdata_i = 0; data_be_i = 4'hF;
        data_gnt_s1_i = 0; data_rvalid_s1_i = 0; data_rdata_s1_i = 0;
        data_gnt_s2_i = 0; data_rvalid_s2_i = 0; data_rdata_s2_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        #2;
        chk("reset_rvalid", 32'(data_rvalid_o), 0);
        chk("reset_gnt", 32'(data_gnt_o), 0);
        chk("reset_req", {30'b0, data_req_s1_o, data_req_s2_o}, 0);
        step();
        step();
        rst_ni = 1;
    endtask

    // Target numbering in the model: 1 = s1, 2 = s2, 3 = internal responder.
    function automatic int decode(input logic [31:0] a);
        if ((a & 32'hFF00_0000) == 32'h1500_0000) return 2;
        if ((a & 32'hFFF0_0000) == 32'h0000_0000) return 1;
`ifdef CV32E40N_DEMUX_DEFAULT_RESP_EN
        return 3;
`else
        return 1;
`endif
    endfunction

    typedef struct { int tgt; logic [31:0] data; int acc; } txn_t;
    typedef struct { int due; logic [31:0] data; } sresp_t;
    txn_t   mq[$];
    sresp_t sq1[$];
    sresp_t sq2[$];

    logic [31:0] bnd [6];

    initial begin
        int cyc, n, t, last, lat, ntxn;
        logic allowed, e_gnt, e_rv, rv1_real, rv2_real, sgnt;
        logic [31:0] d, e_data;

        bnd = '{32'h000F_FFFC, 32'h0010_0000, 32'h14FF_FFFC,
                32'h1500_0000, 32'h15FF_FFFC, 32'h1600_0000};

        do_reset();
        step();

        // Single s1 read, response two cycles later.
        data_req_i = 1; data_addr_i = 32'h0000_0100; data_gnt_s1_i = 1; #3;
        chk("d1_gnt", 32'(data_gnt_o), 1);
        chk("d1_req_s1", 32'(data_req_s1_o), 1);
        chk("d1_req_s2", 32'(data_req_s2_o), 0);
        step(); data_req_i = 0; data_gnt_s1_i = 0; #3;
        chk("d1_rvalid_early", 32'(data_rvalid_o), 0);
        step(); data_rvalid_s1_i = 1; data_rdata_s1_i = 32'h1234_5678; #3;
        chk("d1_rvalid", 32'(data_rvalid_o), 1);
        chk("d1_rdata", data_rdata_o, 32'h1234_5678);
        step(); data_rvalid_s1_i = 0;

        // Target switch s1 -> s2 stalls until s1 has drained.
        data_req_i = 1; data_addr_i = 32'h0000_0100; data_gnt_s1_i = 1; #3;
        chk("d2_gnt_s1", 32'(data_gnt_o), 1);
        step(); data_addr_i = 32'h1500_0004; data_we_i = 1; data_gnt_s2_i = 1; #3;
        chk("d2_stall_req_s2", 32'(data_req_s2_o), 0);
        chk("d2_stall_gnt", 32'(data_gnt_o), 0);
        chk("d2_stall_req_s1", 32'(data_req_s1_o), 0);
        step(); data_rvalid_s1_i = 1; data_rdata_s1_i = 32'hAAAA_0001; #3;
        chk("d2_resp_req_s2", 32'(data_req_s2_o), 0);
        chk("d2_resp_rvalid", 32'(data_rvalid_o), 1);
        step(); data_rvalid_s1_i = 0; #3;
        chk("d2_req_s2", 32'(data_req_s2_o), 1);
        chk("d2_gnt_s2", 32'(data_gnt_o), 1);
        step(); data_req_i = 0; data_we_i = 0; data_gnt_s2_i = 0;
        step(); data_rvalid_s2_i = 1; data_rdata_s2_i = 32'h5555_0002; #3;
        chk("d2_rvalid_s2", 32'(data_rvalid_o), 1);
        chk("d2_rdata_s2", data_rdata_o, 32'h5555_0002);
        step(); data_rvalid_s2_i = 0;

        // Three back-to-back s1 reads with MAX_OUTSTANDING=2.
        data_req_i = 1; data_addr_i = 32'h0000_0200; data_gnt_s1_i = 1; #3;
        chk("d3_gnt0", 32'(data_gnt_o), 1);
        step(); #3;
        chk("d3_gnt1", 32'(data_gnt_o), 1);
        step(); #3;
        chk("d3_gnt2_held", 32'(data_gnt_o), 0);
        step(); data_rvalid_s1_i = 1; data_rdata_s1_i = 32'hC0DE_0001; #3;
        chk("d3_held_at_resp", 32'(data_gnt_o), 0);
        chk("d3_rdata_a", data_rdata_o, 32'hC0DE_0001);
        step(); data_rdata_s1_i = 32'hC0DE_0002; #3;
        chk("d3_accept_and_resp_gnt", 32'(data_gnt_o), 1);
        chk("d3_rdata_b", data_rdata_o, 32'hC0DE_0002);
        step(); data_req_i = 0; data_rdata_s1_i = 32'hC0DE_0003; #3;
        chk("d3_rvalid_c", 32'(data_rvalid_o), 1);
        chk("d3_rdata_c", data_rdata_o, 32'hC0DE_0003);
        step(); #3;
        chk("d3_ignored_at_zero", 32'(data_rvalid_o), 0);
        step(); data_rvalid_s1_i = 0; data_gnt_s1_i = 0;

        // Unmapped access.
        data_req_i = 1; data_addr_i = 32'h8000_0000; data_gnt_s1_i = 1; data_gnt_s2_i = 1; #3;
`ifdef CV32E40N_DEMUX_DEFAULT_RESP_EN
        chk("d4_gnt", 32'(data_gnt_o), 1);
        chk("d4_no_slave_req", {30'b0, data_req_s1_o, data_req_s2_o}, 0);
        step(); data_req_i = 0; #3;
        chk("d4_rvalid", 32'(data_rvalid_o), 1);
        chk("d4_rdata", data_rdata_o, 32'hBADA_DD12);
        step();
`else
        chk("d4_gnt", 32'(data_gnt_o), 1);
        chk("d4_req_s1", {30'b0, data_req_s1_o, data_req_s2_o}, 2);
        step(); data_req_i = 0; data_rvalid_s1_i = 1; data_rdata_s1_i = 32'h0BAD_0001; #3;
        chk("d4_rvalid", 32'(data_rvalid_o), 1);
        chk("d4_rdata", data_rdata_o, 32'h0BAD_0001);
        step(); data_rvalid_s1_i = 0;
`endif
        data_gnt_s2_i = 0;

        // Reset with two accesses outstanding.
        data_req_i = 1; data_addr_i = 32'h0000_0300; data_gnt_s1_i = 1;
        step(); step();
        data_req_i = 0; data_rvalid_s1_i = 1; data_rdata_s1_i = 32'h0000_0077; #3;
        chk("d5_rvalid_before", 32'(data_rvalid_o), 1);
        rst_ni = 0; #1;
        chk("d5_rvalid_in_reset", 32'(data_rvalid_o), 0);
        step(); rst_ni = 1; data_rvalid_s1_i = 0; #1;
        chk("d5_rvalid_after", 32'(data_rvalid_o), 0);
        data_req_i = 1; data_addr_i = 32'h0000_0100; #2;
        chk("d5_gnt_after", 32'(data_gnt_o), 1);

        do_reset();

        // Randomized traffic against the model.
        cyc = 0; ntxn = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle_inputs();
                rst_ni = 0; #1;
                chk("rand_rst_rvalid", 32'(data_rvalid_o), 0);
                chk("rand_rst_req", {30'b0, data_req_s1_o, data_req_s2_o}, 0);
                mq.delete(); sq1.delete(); sq2.delete();
                step();
                rst_ni = 1;
                cyc++;
            end
            data_req_i   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: data_addr_i = {12'h000, 20'($urandom)};
                1: data_addr_i = {8'h15, 24'($urandom)};
                2: data_addr_i = {4'h8, 28'($urandom)};
                default: data_addr_i = bnd[$urandom_range(0, 5)];
            endcase
            data_we_i    = 1'($urandom);
            data_wdata_i = $urandom;
            data_be_i    = 4'($urandom);
            data_gnt_s1_i = ($urandom_range(0, 2) != 0);
            data_gnt_s2_i = ($urandom_range(0, 2) != 0);
            rv1_real = (sq1.size() > 0) && (sq1[0].due <= cyc);
            rv2_real = (sq2.size() > 0) && (sq2[0].due <= cyc);
            data_rvalid_s1_i = rv1_real || ((sq1.size() == 0) && ($urandom_range(0, 7) == 0));
            data_rvalid_s2_i = rv2_real || ((sq2.size() == 0) && ($urandom_range(0, 7) == 0));
            data_rdata_s1_i  = rv1_real ? sq1[0].data : $urandom;
            data_rdata_s2_i  = rv2_real ? sq2[0].data : $urandom;
            #3;

            n = mq.size();
            t = decode(data_addr_i);
            last = (n > 0) ? mq[n-1].tgt : 0;
            allowed = (n < 2) && ((n == 0) || (t == last));
            sgnt = (t == 1) ? data_gnt_s1_i : (t == 2) ? data_gnt_s2_i : 1'b1;
            e_gnt = allowed & sgnt;
            e_rv = 1'b0;
            e_data = 32'h0;
            if (n > 0) begin
                e_data = mq[0].data;
                case (mq[0].tgt)
                    1: e_rv = data_rvalid_s1_i;
                    2: e_rv = data_rvalid_s2_i;
                    default: e_rv = (mq[0].acc == cyc - 1);
                endcase
            end
            chk("rand_gnt", 32'(data_gnt_o), 32'(e_gnt));
            chk("rand_req_s1", 32'(data_req_s1_o), 32'(allowed & data_req_i & (t == 1)));
            chk("rand_req_s2", 32'(data_req_s2_o), 32'(allowed & data_req_i & (t == 2)));
            chk("rand_rvalid", 32'(data_rvalid_o), 32'(e_rv));
            if (e_rv) chk("rand_rdata", data_rdata_o, e_data);
            chk("rand_bcast_addr", data_addr_s2_o, data_addr_i);
            chk("rand_bcast_wdata", data_wdata_s1_o, data_wdata_i);
            chk("rand_bcast_ctl", {27'b0, data_we_s1_o, data_be_s2_o}, {27'b0, data_we_i, data_be_i});

            @(posedge clk_i);
            if (data_req_i && e_gnt) begin
                lat = $urandom_range(1, 4);
                d = (t == 3) ? 32'hBADA_DD12 : $urandom;
                if (t == 1) sq1.push_back('{due: cyc + lat, data: d});
                if (t == 2) sq2.push_back('{due: cyc + lat, data: d});
                mq.push_back('{tgt: t, data: d, acc: cyc});
                ntxn++;
                $display("TXN %0d cyc=%0d tgt=%0d addr=%h we=%0d", ntxn, cyc, t, data_addr_i, data_we_i);
            end
            if (e_rv) void'(mq.pop_front());
            if (rv1_real) void'(sq1.pop_front());
            if (rv2_real) void'(sq2.pop_front());
            cyc++;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
